writeback_arbiter: RTL

- Parametrised successor to the single-source writeback stage.
- Merges results from NUM_SRC producers onto the single register-file write port:
  - channel 0 is the in-order pipeline (ALU/load/auipc/jal, already muxed);
  - channels 1..NUM_SRC-1 are variable-latency units (mul/div, future FPU).
- Side channels are buffered in per-channel FIFOs and drained round-robin when the pipeline slot is free.
- Drives registered write-port signals, a forwarding value and a pending-register mask for the hazard unit.

---
 rtl/writeback_arbiter_if.sv | 29 ++
 rtl/writeback_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter_if.sv
// Result-channel bundle shared by the pipeline and the variable-latency
// units. Channel k occupies bit k of the valid/ready vectors and the k-th
// REG_AW / XLEN wide field of the address and data vectors.
interface writeback_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*REG_AW-1:0] src_rd_addr;
  logic [NUM_SRC*XLEN-1:0]   src_data;

  // Producer side: presents results and watches ready.
  modport master (
    output src_valid,
    output src_rd_addr,
    output src_data,
    input  src_ready
  );

  // Arbiter side: consumes results and grants ready.
  modport slave (
    input  src_valid,
    input  src_rd_addr,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the in-order pipeline (channel 0) with buffered
// variable-latency units (channels 1..NUM_SRC-1) onto one register-file
// write port. The pipeline always has priority; side channels drain their
// FIFOs round-robin whenever the pipeline slot is free.
module writeback_arbiter #(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  writeback_arbiter_if.slave         src,
  output logic                       W_reg_write,
  output logic [REG_AW-1:0]          W_rd_addr,
  output logic [XLEN-1:0]            W_rd,
  output logic [XLEN-1:0]            W_forward_result,
  output logic [$clog2(NUM_SRC)-1:0] W_src_id,
  output logic [2**REG_AW-1:0]       pending_mask
);

  localparam int SW    = $clog2(NUM_SRC);
  localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam int NREG  = 2**REG_AW;
  localparam int NSIDE = NUM_SRC - 1;

  // Per-channel views of the flattened input bus.
  logic [NUM_SRC-1:0][REG_AW-1:0] ch_addr;
  logic [NUM_SRC-1:0][XLEN-1:0]   ch_data;

  // Per-channel FIFO status and heads. Channel 0 has no FIFO; its slots are
  // tied off so the arbiter can index all channels uniformly.
  logic [NUM_SRC-1:0]             ready;
  logic [NUM_SRC-1:0]             empty;
  logic [NUM_SRC-1:0]             push;
  logic [NUM_SRC-1:1]             pop;
  logic [NUM_SRC-1:0][REG_AW-1:0] head_addr;
  logic [NUM_SRC-1:0][XLEN-1:0]   head_data;
  logic [NUM_SRC-1:0][NREG-1:0]   chan_mask;

  logic          pipe_win;
  logic          grant_valid;
  logic [SW-1:0] grant_id;
  logic [SW-1:0] rr_reg;

  assign ch_addr       = src.src_rd_addr;
  assign ch_data       = src.src_data;
  assign src.src_ready = ready;

  // Circular-buffer pointer step; wraps explicitly so non-power-of-two
  // depths would also behave.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Side channel visited at scan position off, starting at pointer start
  // and wrapping from NUM_SRC-1 back to 1 (channel 0 is never scanned).
  function automatic int scan_chan(input int start, input int off);
    return ((start - 1 + off) % NSIDE) + 1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_chan
      if (gi == 0) begin : g_pipe
        // The pipeline is always ready; an x0 result is swallowed and
        // does not claim the write port.
        assign ready[gi]     = 1'b1;
        assign empty[gi]     = 1'b1;
        assign push[gi]      = src.src_valid[gi] && (ch_addr[gi] != '0);
        assign head_addr[gi] = '0;
        assign head_data[gi] = '0;
        assign chan_mask[gi] = '0;
      end else begin : g_fifo
        logic [REG_AW-1:0]    addr_mem [BUF_DEPTH];
        logic [XLEN-1:0]      data_mem [BUF_DEPTH];
        logic [BUF_DEPTH-1:0] live_reg;
        logic [PW-1:0]        wr_ptr_reg;
        logic [PW-1:0]        rd_ptr_reg;
        logic [CW-1:0]        count_reg;
        logic [NREG-1:0]      live_mask;

        // Ready depends on registered occupancy only, so a pop in the same
        // cycle does not make room for a push into a full FIFO.
        assign ready[gi]     = (count_reg != CW'(BUF_DEPTH));
        assign empty[gi]     = (count_reg == '0);
        // x0 results complete the handshake but are never stored.
        assign push[gi]      = src.src_valid[gi] && ready[gi] && (ch_addr[gi] != '0);
        assign pop[gi]       = !pipe_win && grant_valid && (grant_id == SW'(gi));
        assign head_addr[gi] = addr_mem[rd_ptr_reg];
        assign head_data[gi] = data_mem[rd_ptr_reg];

        // Pointer, occupancy and live-entry bookkeeping; reset discards
        // everything buffered, even mid-drain.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            live_reg   <= '0;
          end else begin
            if (push[gi]) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop[gi])  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push[gi], pop[gi]})
              2'b10:   count_reg <= count_reg + CW'(1);
              2'b01:   count_reg <= count_reg - CW'(1);
              default: count_reg <= count_reg;
            endcase
            // Push and pop never hit the same slot: a pop needs count>=1
            // and a push needs count<depth, so the pointers differ.
            for (int e = 0; e < BUF_DEPTH; e++) begin
              if (push[gi] && (wr_ptr_reg == PW'(e))) begin
                live_reg[e] <= 1'b1;
              end else if (pop[gi] && (rd_ptr_reg == PW'(e))) begin
                live_reg[e] <= 1'b0;
              end
            end
          end
        end

        // Payload storage; validity lives in live_reg, so no reset needed.
        always_ff @(posedge clk) begin
          if (push[gi]) begin
            addr_mem[wr_ptr_reg] <= ch_addr[gi];
            data_mem[wr_ptr_reg] <= ch_data[gi];
          end
        end

        // Every live entry marks its destination register as pending.
        always_comb begin
          live_mask = '0;
          for (int e = 0; e < BUF_DEPTH; e++) begin
            if (live_reg[e]) live_mask[addr_mem[e]] = 1'b1;
          end
        end

        assign chan_mask[gi] = live_mask;

        // Issue logic must never send a second write to a register that is
        // still buffered, otherwise writeback order would be lost.
        a_no_dup_pending: assert property (
          @(posedge clk) disable iff (reset)
          push[gi] |-> !pending_mask[ch_addr[gi]]
        );
      end
    end
  endgenerate

  assign pipe_win = push[0];

  // Round-robin pick among non-empty side FIFOs starting at rr_reg.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int off = 0; off < NSIDE; off++) begin
      if (!grant_valid && !empty[SW'(scan_chan(int'(rr_reg), off))]) begin
        grant_valid = 1'b1;
        grant_id    = SW'(scan_chan(int'(rr_reg), off));
      end
    end
  end

  // Fairness pointer moves past a side channel only when it really wrote.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_reg <= SW'(1);
    end else if (!pipe_win && grant_valid) begin
      rr_reg <= (grant_id == SW'(NSIDE)) ? SW'(1) : grant_id + SW'(1);
    end
  end

  // Registered write port: pipeline first, else the FIFO grant, else idle
  // with address/data held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      W_reg_write <= 1'b0;
      W_rd_addr   <= '0;
      W_rd        <= '0;
      W_src_id    <= '0;
    end else if (pipe_win) begin
      W_reg_write <= 1'b1;
      W_rd_addr   <= ch_addr[0];
      W_rd        <= ch_data[0];
      W_src_id    <= '0;
    end else if (grant_valid) begin
      W_reg_write <= 1'b1;
      W_rd_addr   <= head_addr[grant_id];
      W_rd        <= head_data[grant_id];
      W_src_id    <= grant_id;
    end else begin
      W_reg_write <= 1'b0;
    end
  end

  assign W_forward_result = W_rd;

  // Pending set is the union of every channel's live FIFO destinations.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pending_mask = pending_mask | chan_mask[k];
    end
  end

endmodule
